ofmap_deskew_writer: RTL and testbench
======================================

# ofmap_deskew_writer

Parametrised output stage of the convolution datapath, placed between the systolic array's skewed accumulator column outputs and the ofmap BRAM. It removes the per-column skew with a triangular delay line and applies optional ReLU plus shift-and-saturate requantisation. It then packs each aligned row into one memory word and writes a frame of `FRAME_ROWS` rows to consecutive addresses from a programmable base. A one-cycle `finish_o` pulse accompanies the last write.

## Interface
- `PE_SIZE`, 14, number of array columns (elements per row)
- `ACC_WIDTH`, 16, signed width of each incoming accumulator element
- `OUT_WIDTH`, 8, signed width of each stored element
- `SHIFT_WIDTH`, 4, width of the requant shift amount
- `FRAME_ROWS`, 896, rows written per frame
- `MEM_ADDR_WIDTH`, 10, BRAM address width
- `MEM_DATA_WIDTH`, `OUT_WIDTH*PE_SIZE`, BRAM word width (derived; do not override)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `start_i`  in  1  pulse; arms a frame (accepted only in IDLE)
- `base_addr_i`  in  MEM_ADDR_WIDTH  first write address, latched on accepted start
- `relu_en_i`  in  1  ReLU enable, latched on accepted start
- `shift_i`  in  SHIFT_WIDTH  arithmetic right-shift amount, latched on accepted start
- `valid_i`  in  1  marks arrival of the leading element (column PE_SIZE-1) of a row
- `ofmap_row_i`  in  ACC_WIDTH*PE_SIZE  skewed column data; column c occupies bits [(c+1)*ACC_WIDTH-1 -: ACC_WIDTH]
- `mem_d_o`  out  MEM_DATA_WIDTH  write data, column c in bits [(c+1)*OUT_WIDTH-1 -: OUT_WIDTH]
- `mem_addr_o`  out  MEM_ADDR_WIDTH  write address
- `mem_ce_o`  out  1  chip enable (equals `mem_we_o`)
- `mem_we_o`  out  1  write enable
- `finish_o`  out  1  one-cycle pulse coincident with the last write of a frame
- `busy_o`  out  1  high in RUN
- `drop_o`  out  1  sticky; a row reached the write stage while IDLE

## Operation
- Skew contract:
  - Row r has `valid_i` at cycle T_r.
  - Element c of row r is present on `ofmap_row_i` at cycle T_r + (PE_SIZE-1-c).
  - Rows may be back-to-back, one per cycle.
- Deskew:
  - Column c passes through a c-stage register delay; column 0 is undelayed.
  - All elements of row r are therefore aligned at T_r + PE_SIZE-1.
  - A (PE_SIZE-1)-stage valid shift register tracks the alignment.
  - Data delay registers have no reset; only valid stages reset.
- Post-process, per element, signed:
  - v = x >>> shift (arithmetic).
  - If relu_en and v < 0, v = 0.
  - Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Result is registered into `mem_d_o`.
- FSM states IDLE and RUN:
  - IDLE→RUN on `start_i`. Latches base, relu, shift; clears row count and `drop_o`.
  - In RUN, each aligned valid row produces one write: address = base + count, modulo 2^MEM_ADDR_WIDTH (wrap silently); count increments.
  - The write with count == FRAME_ROWS-1 asserts `finish_o`; RUN→IDLE at that edge.
- `start_i` in RUN is ignored, including the finishing cycle.
- Aligned row arriving in IDLE: no write; set `drop_o`. This covers a row arriving in the same cycle as `start_i`, which takes effect next cycle.
- Rows still in the deskew pipe when the frame finishes are dropped and flagged the same way.

## Timing
- Latency: `valid_i` at cycle T → `mem_we_o` at T+PE_SIZE (PE_SIZE-1 deskew + 1 output register).
- Throughput: one row per cycle, no backpressure; the BRAM always accepts.
- `finish_o` is high in the same cycle as the final `mem_we_o`. `busy_o` is low from the next cycle.
- Reset values:
  - `mem_we_o` = `mem_ce_o` = `finish_o` = `busy_o` = `drop_o` = 0.
  - `mem_addr_o` = 0, `mem_d_o` = 0.
  - State IDLE; count 0; all valid stages cleared.
- Reset mid-frame: in-flight rows are discarded, no further writes occur, and `finish_o` is not pulsed.
- Outputs change only on the rising edge of `clk`. Address and data are stable whenever `mem_we_o` is high.

## Test plan
Bench configuration: PE_SIZE=4, ACC_WIDTH=16, OUT_WIDTH=8, FRAME_ROWS=6, MEM_ADDR_WIDTH=4.

- Skewed single row: start with base 2, shift 0, relu 0; drive element values 1,2,3,4 for columns 0..3 with correct skew, `valid_i` at cycle 10 → `mem_we_o` at cycle 14, addr 2, data bytes {4,3,2,1}, no finish.
- Back-to-back frame: 6 consecutive rows, base 0 → addresses 0..5 on 6 consecutive cycles; `finish_o` with addr 5 only; `busy_o` low next cycle.
- Wrap: base 13, 6 rows → addresses 13,14,15,0,1,2; finish on addr 2.
- Requant: shift 2, relu 1; elements 1000, -40, 7, 300 → stored 127, 0, 1, 75. Same with relu 0 → 127, -10, 1, 75.
- Drop and ignored start: row before any start → no write, `drop_o`=1. Second `start_i` mid-frame → base unchanged. Seventh row after finish → dropped, `drop_o`=1.
- Reset mid-frame: after 3 writes, pulse `rst` with 2 rows in flight → no further writes, all outputs 0. A new start at base 0 writes from address 0.

Source files
------------

// File: rtl/ofmap_deskew_writer_if.sv
// ofmap_deskew_writer_if: skewed accumulator row stream in, ofmap BRAM write port out
interface ofmap_deskew_writer_if #(
    parameter int PE_SIZE        = 14,
    parameter int ACC_WIDTH      = 16,
    parameter int OUT_WIDTH      = 8,
    parameter int MEM_ADDR_WIDTH = 10
);
    logic                         valid_i;
    logic [ACC_WIDTH*PE_SIZE-1:0] ofmap_row_i;
    logic [OUT_WIDTH*PE_SIZE-1:0] mem_d_o;
    logic [MEM_ADDR_WIDTH-1:0]    mem_addr_o;
    logic                         mem_ce_o;
    logic                         mem_we_o;
    modport master (output valid_i, ofmap_row_i, input mem_d_o, mem_addr_o, mem_ce_o, mem_we_o);
    modport slave  (input valid_i, ofmap_row_i, output mem_d_o, mem_addr_o, mem_ce_o, mem_we_o);
endinterface

// File: rtl/ofmap_deskew_writer.sv
// ofmap_deskew_writer: deskews array columns, requantises, and writes one frame of rows to the ofmap BRAM
module ofmap_deskew_writer #(
    parameter int PE_SIZE        = 14,
    parameter int ACC_WIDTH      = 16,
    parameter int OUT_WIDTH      = 8,
    parameter int SHIFT_WIDTH    = 4,
    parameter int FRAME_ROWS     = 896,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_DATA_WIDTH = OUT_WIDTH*PE_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
    input  logic                      relu_en_i,
    input  logic [SHIFT_WIDTH-1:0]    shift_i,
    output logic                      finish_o,
    output logic                      busy_o,
    output logic                      drop_o,
    ofmap_deskew_writer_if.slave      bus
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam int CNT_W = $clog2(FRAME_ROWS + 1);
    localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MIN_V = ~MAX_V;

    state_t                            state, state_nxt;
    logic [CNT_W-1:0]                  count;
    logic [MEM_ADDR_WIDTH-1:0]         base_q;
    logic                              relu_q;
    logic [SHIFT_WIDTH-1:0]            shift_q;
    logic [PE_SIZE-2:0]                vld_sr;
    logic [PE_SIZE-1:0][ACC_WIDTH-1:0] aligned;
    logic [MEM_DATA_WIDTH-1:0]         d_nxt;
    logic                              row_vld, accept, wr, last;

    function automatic logic [OUT_WIDTH-1:0] quant(input logic signed [ACC_WIDTH-1:0] x,
                                                   input logic [SHIFT_WIDTH-1:0] sh, input logic relu);
        logic signed [ACC_WIDTH-1:0] v;
        v = x >>> sh;
        v = (relu && v < 0) ? '0 : v;
        return (v > MAX_V) ? MAX_V[OUT_WIDTH-1:0] : (v < MIN_V) ? MIN_V[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0];
    endfunction

    // column c arrives c cycles early, so a c-stage delay lines every column up with column 0
    for (genvar c = 0; c < PE_SIZE; c++) begin : g_col
        logic [ACC_WIDTH-1:0] x;
        assign x = bus.ofmap_row_i[(c+1)*ACC_WIDTH-1 -: ACC_WIDTH];
        if (c == 0) begin : g_direct
            assign aligned[c] = x;
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] sr [c];
            always_ff @(posedge clk) begin
                sr[0] <= x;
                for (int k = 1; k < c; k++) sr[k] <= sr[k-1];
            end
            assign aligned[c] = sr[c-1];
        end
        assign d_nxt[(c+1)*OUT_WIDTH-1 -: OUT_WIDTH] = quant(aligned[c], shift_q, relu_q);
    end

    always_ff @(posedge clk)
        vld_sr <= rst ? '0 : (vld_sr << 1) | (PE_SIZE-1)'(bus.valid_i);

    assign row_vld = vld_sr[PE_SIZE-2];

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb
        state_nxt = (state == IDLE) ? (accept ? RUN : IDLE) : (last ? IDLE : RUN);

    // finish_o high means the frame just ended; a start in that cycle is still ignored
    always_comb begin
        accept = start_i && state == IDLE && !finish_o;
        wr     = row_vld && state == RUN;
        last   = wr && count == CNT_W'(FRAME_ROWS - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= '0;
            base_q         <= '0;
            relu_q         <= 1'b0;
            shift_q        <= '0;
            drop_o         <= 1'b0;
            finish_o       <= 1'b0;
            bus.mem_we_o   <= 1'b0;
            bus.mem_addr_o <= '0;
            bus.mem_d_o    <= '0;
        end else begin
            if (accept) begin
                base_q  <= base_addr_i;
                relu_q  <= relu_en_i;
                shift_q <= shift_i;
            end
            count        <= accept ? '0 : wr ? count + 1'b1 : count;
            drop_o       <= (drop_o && !accept) || (row_vld && state == IDLE);
            finish_o     <= last;
            bus.mem_we_o <= wr;
            if (wr) begin
                bus.mem_addr_o <= base_q + MEM_ADDR_WIDTH'(count);
                bus.mem_d_o    <= d_nxt;
            end
        end
    end

    assign bus.mem_ce_o = bus.mem_we_o;
    assign busy_o       = state == RUN || finish_o;
endmodule

// File: tb/tb_ofmap_deskew_writer.sv
// tb_ofmap_deskew_writer: directed self-checking bench for ofmap_deskew_writer
module tb_ofmap_deskew_writer;
    localparam int P = 4, AW = 16, OW = 8, SW = 4, FR = 6, MA = 4;

    logic          clk = 1'b0, rst = 1'b1, start_i = 1'b0, relu_en_i = 1'b0;
    logic [MA-1:0] base_addr_i = '0;
    logic [SW-1:0] shift_i = '0;
    logic          finish_o, busy_o, drop_o;
    int            checks = 0, failures = 0, cyc = 0, t0;
    logic [AW-1:0] rows [0:7][0:P-1];

    typedef struct packed {
        int            t;
        logic [MA-1:0] a;
        logic [OW*P-1:0] d;
        logic          f;
        logic          b;
        logic          ce;
    } wr_t;
    wr_t  wq[$];
    logic prev_fin = 1'b0, busy_post = 1'b1;

    ofmap_deskew_writer_if #(.PE_SIZE(P), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .MEM_ADDR_WIDTH(MA)) bus();

    ofmap_deskew_writer #(
        .PE_SIZE(P), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW),
        .FRAME_ROWS(FR), .MEM_ADDR_WIDTH(MA)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
        .relu_en_i(relu_en_i), .shift_i(shift_i), .finish_o(finish_o),
        .busy_o(busy_o), .drop_o(drop_o), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (prev_fin) busy_post = busy_o;
        prev_fin = finish_o;
        if (bus.mem_we_o) begin
            w.t = cyc; w.a = bus.mem_addr_o; w.d = bus.mem_d_o;
            w.f = finish_o; w.b = busy_o; w.ce = bus.mem_ce_o;
            wq.push_back(w);
        end
    end

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wq.delete();
        busy_post = 1'b1;
    endtask

    task automatic start(input logic [MA-1:0] b, input logic [SW-1:0] s, input logic r);
        @(posedge clk); #1;
        start_i = 1'b1; base_addr_i = b; shift_i = s; relu_en_i = r;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // drives n back-to-back rows with the array skew; optional start/reset pulse at row slot k
    task automatic drive(input int n, input int st_at, input logic [MA-1:0] st_base, input int rst_at, output int ts);
        for (int k = 0; k < n + P - 1; k++) begin
            @(posedge clk); #1;
            if (k == 0) ts = cyc;
            bus.valid_i = k < n;
            start_i = k == st_at;
            base_addr_i = st_base;
            rst = k == rst_at;
            for (int c = 0; c < P; c++) begin
                int r;
                r = k - (P - 1 - c);
                bus.ofmap_row_i[c*AW +: AW] = (r >= 0 && r < n) ? rows[r][c] : '0;
            end
        end
        @(posedge clk); #1;
        bus.valid_i = 1'b0; bus.ofmap_row_i = '0; start_i = 1'b0; rst = 1'b0;
    endtask

    task automatic settle;
        repeat (P + 2) @(posedge clk);
        #1;
    endtask

    task automatic fill_rows;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < P; c++) rows[r][c] = 16'(r * 16 + c);
    endtask

    task automatic test_reset;
        do_reset;
        @(negedge clk);
        checks++;
        if ({bus.mem_we_o, bus.mem_ce_o, finish_o, busy_o, drop_o} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=00000", {bus.mem_we_o, bus.mem_ce_o, finish_o, busy_o, drop_o});
        end
        checks++;
        if (bus.mem_addr_o !== '0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", bus.mem_addr_o); end
        checks++;
        if (bus.mem_d_o !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.mem_d_o); end
    endtask

    task automatic test_drop_idle;
        rows[0][0] = 16'd1; rows[0][1] = 16'd2; rows[0][2] = 16'd3; rows[0][3] = 16'd4;
        drive(1, -1, '0, -1, t0);
        settle;
        checks++;
        if (wq.size() != 0) begin failures++; $display("FAIL idle_nowrite got=%0d writes exp=0", wq.size()); end
        checks++;
        if (drop_o !== 1'b1) begin failures++; $display("FAIL idle_drop got=%b exp=1", drop_o); end
    endtask

    task automatic test_single_row;
        start(4'd2, 4'd0, 1'b0);
        checks++;
        if ({busy_o, drop_o} !== 2'b10) begin failures++; $display("FAIL start_busy_drop got=%b exp=10", {busy_o, drop_o}); end
        drive(1, -1, 4'd2, -1, t0);
        settle;
        checks++;
        if (wq.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", wq.size()); end
        if (wq.size() > 0) begin
            checks++;
            if (wq[0].t - t0 != P) begin failures++; $display("FAIL single_latency got=%0d exp=%0d", wq[0].t - t0, P); end
            checks++;
            if (wq[0].a !== 4'd2) begin failures++; $display("FAIL single_addr got=%0d exp=2", wq[0].a); end
            checks++;
            if (wq[0].d !== 32'h04030201) begin failures++; $display("FAIL single_data got=%h exp=04030201", wq[0].d); end
            checks++;
            if ({wq[0].f, wq[0].ce} !== 2'b01) begin failures++; $display("FAIL single_fin_ce got=%b exp=01", {wq[0].f, wq[0].ce}); end
        end
    endtask

    task automatic test_back_to_back(input logic [MA-1:0] base, input string nm);
        logic [OW*P-1:0] exp_d;
        do_reset;
        fill_rows;
        start(base, 4'd0, 1'b0);
        drive(FR, -1, base, -1, t0);
        settle;
        checks++;
        if (wq.size() != FR) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", nm, wq.size(), FR); end
        for (int i = 0; i < wq.size() && i < FR; i++) begin
            for (int c = 0; c < P; c++) exp_d[c*OW +: OW] = 8'(i * 16 + c);
            checks++;
            if (wq[i].a !== MA'(base + i)) begin failures++; $display("FAIL %s_addr%0d got=%0d exp=%0d", nm, i, wq[i].a, MA'(base + i)); end
            checks++;
            if (wq[i].d !== exp_d) begin failures++; $display("FAIL %s_data%0d got=%h exp=%h", nm, i, wq[i].d, exp_d); end
            checks++;
            if (wq[i].f !== (i == FR - 1)) begin failures++; $display("FAIL %s_finish%0d got=%b exp=%b", nm, i, wq[i].f, i == FR - 1); end
            checks++;
            if (wq[i].t != t0 + P + i) begin failures++; $display("FAIL %s_cycle%0d got=%0d exp=%0d", nm, i, wq[i].t - t0, P + i); end
        end
        if (wq.size() == FR) begin
            checks++;
            if (wq[FR-1].b !== 1'b1) begin failures++; $display("FAIL %s_busy_at_finish got=%b exp=1", nm, wq[FR-1].b); end
        end
        checks++;
        if (busy_post !== 1'b0) begin failures++; $display("FAIL %s_busy_after got=%b exp=0", nm, busy_post); end
    endtask

    task automatic test_requant;
        logic [OW*P-1:0] exp_d [0:3];
        exp_d[0] = 32'h4B01007F; exp_d[1] = 32'h01007F00;
        exp_d[2] = 32'h4B01F67F; exp_d[3] = 32'h01FF7F80;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset;
            rows[0][0] = 16'd1000; rows[0][1] = -16'sd40;   rows[0][2] = 16'd7;   rows[0][3] = 16'd300;
            rows[1][0] = -16'sd1000; rows[1][1] = 16'd512; rows[1][2] = -16'sd1; rows[1][3] = 16'd4;
            start(4'd0, 4'd2, pass == 0);
            drive(2, -1, '0, -1, t0);
            settle;
            checks++;
            if (wq.size() != 2) begin failures++; $display("FAIL requant%0d_count got=%0d exp=2", pass, wq.size()); end
            for (int i = 0; i < wq.size() && i < 2; i++) begin
                checks++;
                if (wq[i].d !== exp_d[pass*2+i]) begin
                    failures++; $display("FAIL requant%0d_row%0d got=%h exp=%h", pass, i, wq[i].d, exp_d[pass*2+i]);
                end
            end
        end
    endtask

    task automatic test_ignored_start_and_late_row;
        do_reset;
        fill_rows;
        start(4'd3, 4'd0, 1'b0);
        drive(FR + 1, 2, 4'd9, -1, t0);
        settle;
        checks++;
        if (wq.size() != FR) begin failures++; $display("FAIL late_count got=%0d exp=%0d", wq.size(), FR); end
        for (int i = 0; i < wq.size() && i < FR; i++) begin
            checks++;
            if (wq[i].a !== MA'(3 + i)) begin failures++; $display("FAIL late_addr%0d got=%0d exp=%0d", i, wq[i].a, 3 + i); end
        end
        checks++;
        if ({drop_o, busy_o} !== 2'b10) begin failures++; $display("FAIL late_drop_busy got=%b exp=10", {drop_o, busy_o}); end
    endtask

    task automatic test_reset_mid_frame;
        do_reset;
        fill_rows;
        start(4'd5, 4'd0, 1'b0);
        drive(5, -1, '0, 6, t0);
        settle;
        checks++;
        if (wq.size() != 3) begin failures++; $display("FAIL midrst_count got=%0d exp=3", wq.size()); end
        for (int i = 0; i < wq.size() && i < 3; i++) begin
            checks++;
            if ({wq[i].a, wq[i].f} !== {MA'(5 + i), 1'b0}) begin
                failures++; $display("FAIL midrst_wr%0d got=addr %0d fin %b exp=addr %0d fin 0", i, wq[i].a, wq[i].f, 5 + i);
            end
        end
        @(negedge clk);
        checks++;
        if ({bus.mem_we_o, bus.mem_ce_o, finish_o, busy_o, drop_o, bus.mem_addr_o, bus.mem_d_o} !== '0) begin
            failures++; $display("FAIL midrst_outputs got=%b%b%b%b%b addr=%0d d=%h exp=all zero",
                bus.mem_we_o, bus.mem_ce_o, finish_o, busy_o, drop_o, bus.mem_addr_o, bus.mem_d_o);
        end
        wq.delete();
        rows[0][0] = 16'd9; rows[0][1] = 16'd8; rows[0][2] = 16'd7; rows[0][3] = 16'd6;
        start(4'd0, 4'd0, 1'b0);
        drive(1, -1, '0, -1, t0);
        settle;
        checks++;
        if (wq.size() != 1) begin failures++; $display("FAIL restart_count got=%0d exp=1", wq.size()); end
        if (wq.size() > 0) begin
            checks++;
            if ({wq[0].a, wq[0].d} !== {4'd0, 32'h06070809}) begin
                failures++; $display("FAIL restart_wr got=addr %0d d=%h exp=addr 0 d=06070809", wq[0].a, wq[0].d);
            end
        end
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.ofmap_row_i = '0;
        test_reset;
        test_drop_idle;
        test_single_row;
        test_back_to_back(4'd0, "b2b");
        test_back_to_back(4'd13, "wrap");
        test_requant;
        test_ignored_start_and_late_row;
        test_reset_mid_frame;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
